uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, STOP_BIT stop periods.
// All outputs are registered; each bit period is BAUD_DIV clocks.
module uart_tx #(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BIT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BIT - 1);
  localparam bit PARITY_EN = (PARITY_TYPE == 1) || (PARITY_TYPE == 2);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
  logic                 stopCnt_q, stopCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 bitEnd;

  assign bitEnd = (cnt_q == CNT_LAST);

  // tx_d always reflects the state being entered, so tx stays a pure register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    stopCnt_d = stopCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (valid && ready_q) begin
          shift_d   = data_in;
          parity_d  = (PARITY_TYPE == 2) ? ~(^data_in) : (^data_in);
          cnt_d     = '0;
          bitIdx_d  = '0;
          stopCnt_d = 1'b0;
          state_d   = START;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (bitIdx_q == IDX_LAST) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (stopCnt_q == STOP_LAST) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stopCnt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      stopCnt_q <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      stopCnt_q <= stopCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
